rom_dumper: RTL and testbench

//  Reads a range of program ROM words and streams them as a framed byte stream to a UART

---
 rtl/prog_pkg.sv | 29 ++
 rtl/byte_escaper.sv | 17 +
 rtl/rom_dumper.sv | 160 ++++++++++++++++
 tb/tb_rom_dumper.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// Shared framing symbols and state encoding for the serial ROM loader and dumper.
// The loader and the dumper must agree on these byte values.
package prog_pkg;

  localparam logic [7:0] START_SYM = 8'h73;  // 's'
  localparam logic [7:0] END_SYM   = 8'h65;  // 'e'
  localparam logic [7:0] ESC_SYM   = 8'h71;  // 'q'
  localparam logic [7:0] SYNC_SYM  = 8'h78;  // 'x'
  localparam logic [7:0] PAD_SYM   = 8'h0A;

  typedef enum logic [3:0] {
    D_IDLE,
    D_PRE,
    D_SYNC,
    D_FETCH,
    D_WAIT,
    D_BYTE,
    D_ESC,
    D_NEXT,
    D_END,
    D_PAD
  } dump_state_t;

  // Bytes that would be mistaken for framing and must be preceded by ESC_SYM.
  function automatic logic is_special(input logic [7:0] b);
    return (b == START_SYM) || (b == END_SYM) || (b == ESC_SYM);
  endfunction

endpackage

// File: rtl/byte_escaper.sv
// Escape sequencer: a framing byte goes out as ESC_SYM first and then raw in the
// escape phase; ordinary bytes always go out raw.
module byte_escaper
  import prog_pkg::*;
(
  input  logic [7:0] raw,
  input  logic       esc_phase,
  output logic       special,
  output logic [7:0] out_byte
);

  always_comb begin
    special  = is_special(raw);
    out_byte = (special && !esc_phase) ? ESC_SYM : raw;
  end

endmodule

// File: rtl/rom_dumper.sv
// Reads a range of ROM words and streams them, LSB first and escaped, in the
// serial loader's framing: preamble, sync, data, end, pad.
module rom_dumper
  import prog_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int CNT_W   = 30,
  parameter int PRE_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              abort,
  output logic              rom_ren,
  output logic [31:0]       rom_raddr,
  input  logic [31:0]       rom_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int PRE_W = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;

  dump_state_t       state, state_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  remaining_dec;
  logic [31:0]       word_q;
  logic [1:0]        byte_idx;
  logic [PRE_W-1:0]  pre_cnt;
  logic              abort_q;
  logic              rd_vld;

  logic [7:0]        cur_byte;
  logic [7:0]        esc_byte;
  logic              special;
  logic              sending;
  logic [7:0]        sym;
  logic              accept;
  logic              abort_now;
  logic              abort_byte;
  logic              load;

  assign cur_byte = word_q[{byte_idx, 3'b000} +: 8];

  byte_escaper u_esc (
    .raw       (cur_byte),
    .esc_phase (state == D_ESC),
    .special   (special),
    .out_byte  (esc_byte)
  );

  always_comb begin
    sending       = 1'b0;
    sym           = 8'h00;
    accept        = tx_valid & tx_ready;
    abort_now     = abort | abort_q;
    // Abort may only cut the frame between bytes, never inside an escape pair.
    abort_byte    = (state == D_BYTE) && !tx_valid && abort_now;
    remaining_dec = (remaining != '0) ? remaining - CNT_W'(1) : '0;
    state_d       = state;

    case (state)
      D_PRE:       begin sending = 1'b1; sym = START_SYM; end
      D_SYNC:      begin sending = 1'b1; sym = SYNC_SYM;  end
      D_BYTE,
      D_ESC:       begin sending = 1'b1; sym = esc_byte;  end
      D_END:       begin sending = 1'b1; sym = END_SYM;   end
      D_PAD:       begin sending = 1'b1; sym = PAD_SYM;   end
      default:     ;
    endcase

    load = sending && !tx_valid && !abort_byte;

    case (state)
      D_IDLE:  if (start) state_d = D_PRE;
      D_PRE:   if (accept && pre_cnt == PRE_W'(PRE_LEN - 1)) state_d = D_SYNC;
      D_SYNC:  if (accept) state_d = (remaining == '0) ? D_END : D_FETCH;
      D_FETCH: state_d = abort_now ? D_END : D_WAIT;
      D_WAIT:  if (rd_vld) state_d = D_BYTE;
      D_BYTE: begin
        if (abort_byte)  state_d = D_END;
        else if (accept) state_d = special ? D_ESC : D_NEXT;
      end
      D_ESC:   if (accept) state_d = D_NEXT;
      D_NEXT: begin
        if (byte_idx == 2'd3) state_d = (remaining_dec != '0) ? D_FETCH : D_END;
        else                  state_d = D_BYTE;
      end
      D_END:   if (accept) state_d = D_PAD;
      D_PAD:   if (accept) state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state     <= D_IDLE;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      rom_ren   <= 1'b0;
      rom_raddr <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      byte_idx  <= 2'd0;
      pre_cnt   <= '0;
      abort_q   <= 1'b0;
      rd_vld    <= 1'b0;
    end else begin
      state   <= state_d;
      done    <= 1'b0;
      rom_ren <= (state == D_FETCH) && !abort_now;
      // rom_rdata is valid the cycle after rom_ren, i.e. when rd_vld is high.
      rd_vld  <= rom_ren;

      if (state == D_FETCH && !abort_now) rom_raddr <= 32'({cur_addr, 2'b00});

      if (accept)    tx_valid <= 1'b0;
      else if (load) begin
        tx_valid <= 1'b1;
        tx_data  <= sym;
      end

      if (state == D_IDLE) abort_q <= 1'b0;
      else if (abort)      abort_q <= 1'b1;

      case (state)
        D_IDLE: if (start) begin
          busy    <= 1'b1;
          pre_cnt <= '0;
        end
        D_PRE:  if (accept) pre_cnt <= pre_cnt + PRE_W'(1);
        D_WAIT: if (rd_vld) byte_idx <= 2'd0;
        D_NEXT: if (byte_idx != 2'd3) byte_idx <= byte_idx + 2'd1;
        D_PAD:  if (accept) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == D_IDLE && start) begin
      cur_addr  <= base_addr;
      remaining <= word_count;
    end else if (state == D_NEXT && byte_idx == 2'd3) begin
      cur_addr  <= cur_addr + ADDR_W'(1);
      remaining <= remaining_dec;
    end
    if (state == D_WAIT && rd_vld) word_q <= rom_rdata;
  end

endmodule

// File: tb/tb_rom_dumper.sv
// Directed bench for rom_dumper: framing, escaping, flow control, abort and reset.
module tb_rom_dumper;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        start;
  logic [29:0] base_addr;
  logic [29:0] word_count;
  logic        abort;
  logic        rom_ren;
  logic [31:0] rom_raddr;
  logic [31:0] rom_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic        done;

  rom_dumper dut (
    .clk        (clk),
    .rst_in     (rst_in),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .abort      (abort),
    .rom_ren    (rom_ren),
    .rom_raddr  (rom_raddr),
    .rom_rdata  (rom_rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  always @(posedge clk) if (rom_ren) rom_rdata <= mem[rom_raddr[9:2]];

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  got_q[$];
  logic [31:0] rd_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] exp_rd[$];
  int          done_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stall_prev) begin
      chk("hold_valid", {31'd0, tx_valid}, 32'd1);
      chk("hold_data", {24'd0, tx_data}, {24'd0, stall_data});
    end
    stall_prev = tx_valid && !tx_ready && !rst_in;
    stall_data = tx_data;
    if (tx_valid && tx_ready && !rst_in) got_q.push_back(tx_data);
    if (rom_ren) rd_q.push_back(rom_raddr);
    if (done) done_cnt++;
  end

  task automatic clear_mon();
    got_q.delete();
    rd_q.delete();
    done_cnt = 0;
  endtask

  task automatic kick(input logic [29:0] b, input logic [29:0] n, input logic ab);
    @(posedge clk); #1;
    base_addr = b; word_count = n; start = 1'b1; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit rnd);
    bit seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk); #1;
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      if (done) seen = 1'b1;
    end
    tx_ready = 1'b1;
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_stream(input string tag);
    logic [31:0] v;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      v = 'x;
      if (i < got_q.size()) v = {24'd0, got_q[i]};
      chk($sformatf("%s_byte%0d", tag, i), v, {24'd0, exp_q[i]});
    end
    chk({tag, "_done_pulses"}, done_cnt, 32'd1);
    chk({tag, "_reads"}, rd_q.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++) begin
      v = 'x;
      if (i < rd_q.size()) v = rd_q[i];
      chk($sformatf("%s_raddr%0d", tag, i), v, exp_rd[i]);
    end
  endtask

  // Independent loader-side decode: unescape the data section and rebuild words.
  task automatic decode_check(input string tag, input int base, input int n);
    int          i = 0;
    int          nb = 0;
    logic [31:0] w = 32'd0;
    int          nw = 0;
    while (i < got_q.size() && got_q[i] != 8'h78) i++;
    i++;
    while (i < got_q.size() && got_q[i] != 8'h65) begin
      if (got_q[i] == 8'h71) i++;
      if (i < got_q.size()) begin
        w[8*nb +: 8] = got_q[i];
        nb++;
        if (nb == 4) begin
          chk($sformatf("%s_word%0d", tag, nw), w, mem[base + nw]);
          nw++; nb = 0; w = 32'd0;
        end
      end
      i++;
    end
    chk({tag, "_words"}, nw, n);
  endtask

  initial begin
    bit hit;
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[0] = 32'h04030201;
    mem[1] = 32'h0A657178;
    mem[2] = 32'hDEADBE73;
    mem[5] = 32'h71657300;
    mem[6] = 32'h11223344;
    rst_in = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    base_addr = '0; word_count = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rom_ren", {31'd0, rom_ren}, 32'd0);
    chk("rst_raddr", rom_raddr, 32'd0);
    rst_in = 1'b0;

    // Single word, plus a start while busy that must be ignored
    clear_mon();
    kick(30'd0, 30'd1, 1'b0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    repeat (6) @(posedge clk);
    #1; base_addr = 30'd9; word_count = 30'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done("t1", 1'b0);
    exp_q = '{8'h73, 8'h73, 8'h73, 8'h73, 8'h78, 8'h01, 8'h02, 8'h03, 8'h04, 8'h65, 8'h0A};
    exp_rd = '{32'h0};
    check_stream("t1");

    // Escaped bytes; abort in the same cycle as start is dropped
    clear_mon();
    kick(30'd5, 30'd1, 1'b1);
    wait_done("t2", 1'b0);
    exp_q = '{8'h73, 8'h73, 8'h73, 8'h73, 8'h78, 8'h00, 8'h71, 8'h73, 8'h71, 8'h65,
              8'h71, 8'h71, 8'h65, 8'h0A};
    exp_rd = '{32'h14};
    check_stream("t2");

    // Empty range
    clear_mon();
    kick(30'd3, 30'd0, 1'b0);
    wait_done("t3", 1'b0);
    exp_q = '{8'h73, 8'h73, 8'h73, 8'h73, 8'h78, 8'h65, 8'h0A};
    exp_rd.delete();
    check_stream("t3");

    // Three words under random back-pressure
    clear_mon();
    kick(30'd0, 30'd3, 1'b0);
    wait_done("t4", 1'b1);
    exp_q = '{8'h73, 8'h73, 8'h73, 8'h73, 8'h78, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h78, 8'h71, 8'h71, 8'h71, 8'h65, 8'h0A,
              8'h71, 8'h73, 8'hBE, 8'hAD, 8'hDE, 8'h65, 8'h0A};
    exp_rd = '{32'h0, 32'h4, 32'h8};
    check_stream("t4");
    decode_check("t4", 0, 3);

    // Abort while the ESC of an escape pair is held by back-pressure
    clear_mon();
    kick(30'd5, 30'd2, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clk); #1;
      if (tx_valid && tx_data == 8'h71) hit = 1'b1;
    end
    chk("t5_esc_seen", {31'd0, hit}, 32'd1);
    tx_ready = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; tx_ready = 1'b1;
    wait_done("t5", 1'b0);
    exp_q = '{8'h73, 8'h73, 8'h73, 8'h73, 8'h78, 8'h00, 8'h71, 8'h73, 8'h65, 8'h0A};
    exp_rd = '{32'h14};
    check_stream("t5");

    // Abort during the preamble takes effect at the first fetch
    clear_mon();
    kick(30'd0, 30'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    wait_done("t7", 1'b0);
    exp_q = '{8'h73, 8'h73, 8'h73, 8'h73, 8'h78, 8'h65, 8'h0A};
    exp_rd.delete();
    check_stream("t7");

    // Reset mid-stream, then a fresh transfer
    clear_mon();
    kick(30'd0, 30'd1, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk); #1;
      if (tx_valid) hit = 1'b1;
    end
    chk("t6_valid_seen", {31'd0, hit}, 32'd1);
    rst_in = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_in = 1'b0;
    clear_mon();
    kick(30'd0, 30'd1, 1'b0);
    wait_done("t6", 1'b0);
    exp_q = '{8'h73, 8'h73, 8'h73, 8'h73, 8'h78, 8'h01, 8'h02, 8'h03, 8'h04, 8'h65, 8'h0A};
    exp_rd = '{32'h0};
    check_stream("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
